// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: start/config, comparator input, phase strobes and result handshake of the ADC sequencer
interface adc_seq_ctrl_if #(
    parameter int NCOMP_MAX = 16
);
    logic                 start;
    logic [4:0]           cfg_ncomp;
    logic                 comp_out;
    logic                 seq_init;
    logic                 seq_samp;
    logic                 seq_comp;
    logic                 seq_update;
    logic                 busy;
    logic [NCOMP_MAX-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 overrun;
    modport master (
        input  start, cfg_ncomp, comp_out, result_ready,
        output seq_init, seq_samp, seq_comp, seq_update, busy, result, result_valid, overrun
    );
    modport slave (
        output start, cfg_ncomp, comp_out, result_ready,
        input  seq_init, seq_samp, seq_comp, seq_update, busy, result, result_valid, overrun
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: SAR conversion sequencer and result collector; define ADC_SEQ_CONT_EN for free-running mode with overrun
module adc_seq_ctrl #(
    parameter int NCOMP_MAX  = 16,
    parameter int INIT_CYC   = 2,
    parameter int SAMP_CYC   = 4,
    parameter int COMP_CYC   = 2,
    parameter int UPDATE_CYC = 1
) (
    input logic clk,
    input logic rst_n,
    adc_seq_ctrl_if.master io
);
    typedef enum logic [2:0] {IDLE, INIT, SAMP, COMP, UPDATE, DONE} state_t;
    localparam logic [4:0] NMAX = 5'(NCOMP_MAX);
    state_t               state;
    logic [7:0]           cnt;
    logic [4:0]           n;
    logic [4:0]           bitcnt;
    logic [NCOMP_MAX-1:0] sreg;
    logic [NCOMP_MAX-1:0] sh;
    logic [4:0]           n_cfg;
    logic                 accept;
    // next shift value, clamped comparison count and start acceptance
    always_comb begin
        sh = {sreg[NCOMP_MAX-2:0], io.comp_out};
        n_cfg = (io.cfg_ncomp == 5'd0 || io.cfg_ncomp > NMAX) ? NMAX : io.cfg_ncomp;
`ifdef ADC_SEQ_CONT_EN
        accept = io.start && (state == DONE || !io.result_valid || io.result_ready);
`else
        accept = io.start && (!io.result_valid || io.result_ready);
`endif
    end
    // phase sequencing, bit collection and result handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            n               <= '0;
            bitcnt          <= '0;
            sreg            <= '0;
            io.seq_init     <= 1'b0;
            io.seq_samp     <= 1'b0;
            io.seq_comp     <= 1'b0;
            io.seq_update   <= 1'b0;
            io.busy         <= 1'b0;
            io.result       <= '0;
            io.result_valid <= 1'b0;
            io.overrun      <= 1'b0;
        end else begin
            if (io.result_valid && io.result_ready) io.result_valid <= 1'b0;
`ifdef ADC_SEQ_CONT_EN
            if (state == IDLE && io.start) io.overrun <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state       <= INIT;
                        io.seq_init <= 1'b1;
                        io.busy     <= 1'b1;
                        cnt         <= 8'(INIT_CYC - 1);
                        n           <= n_cfg;
                        bitcnt      <= '0;
                        sreg        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                INIT: begin
                    if (cnt == 8'd0) begin
                        state       <= SAMP;
                        io.seq_init <= 1'b0;
                        io.seq_samp <= 1'b1;
                        cnt         <= 8'(SAMP_CYC - 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SAMP: begin
                    if (cnt == 8'd0) begin
                        state       <= COMP;
                        io.seq_samp <= 1'b0;
                        io.seq_comp <= 1'b1;
                        cnt         <= 8'(COMP_CYC - 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                COMP: begin
                    if (cnt == 8'd0) begin
                        sreg        <= sh;
                        bitcnt      <= bitcnt + 5'd1;
                        io.seq_comp <= 1'b0;
                        if (bitcnt == n - 5'd1) begin
                            state   <= DONE;
                            io.busy <= 1'b0;
                            if (!io.result_valid || io.result_ready) begin
                                io.result       <= sh;
                                io.result_valid <= 1'b1;
                            end
`ifdef ADC_SEQ_CONT_EN
                            else io.overrun <= 1'b1;
`endif
                        end else begin
                            state         <= UPDATE;
                            io.seq_update <= 1'b1;
                            cnt           <= 8'(UPDATE_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                UPDATE: begin
                    if (cnt == 8'd0) begin
                        state         <= COMP;
                        io.seq_update <= 1'b0;
                        io.seq_comp   <= 1'b1;
                        cnt           <= 8'(COMP_CYC - 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed checks of adc_seq_ctrl sequencing, clamp, backpressure, abort and free-running mode
module tb_adc_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   len;
    logic [3:0] stb;
    bit   [3:0] bs [19] = '{4'd0, 4'd8, 4'd8, 4'd4, 4'd4, 4'd4, 4'd4, 4'd2, 4'd2, 4'd1,
                            4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd0};
    bit         cv [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    adc_seq_ctrl_if bus ();
    adc_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .io(bus.master));
    assign stb = {bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update};
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run_conv(input logic [4:0] ncfg, output int l);
        bus.cfg_ncomp = ncfg;
        bus.comp_out  = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        l = 0;
        while (bus.busy && l < 200) begin
            l++;
            tick();
        end
    endtask
    initial begin
        rst_n            = 1'b0;
        bus.start        = 1'b1;
        bus.cfg_ncomp    = 5'd4;
        bus.comp_out     = 1'b0;
        bus.result_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("reset_out", 32'({stb, bus.busy, bus.result_valid, bus.overrun, bus.result}), 32'd0);
        end
        rst_n = 1'b1;
        chk("release_idle", 32'({stb, bus.busy}), 32'd0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
            bus.comp_out = cv[c];
            chk($sformatf("basic_stb_c%0d", c), 32'(stb), 32'(bs[c]));
            chk($sformatf("basic_busy_c%0d", c), 32'(bus.busy), (c <= 17) ? 32'd1 : 32'd0);
        end
        chk("basic_result", 32'(bus.result), 32'h000B);
        chk("basic_valid", 32'(bus.result_valid), 32'd1);
        tick();
        bus.start     = 1'b1;
        bus.cfg_ncomp = 5'd1;
        tick();
        tick();
        chk("bp_ignored", 32'({stb, bus.busy}), 32'd0);
        chk("bp_held_result", 32'(bus.result), 32'h000B);
        chk("bp_held_valid", 32'(bus.result_valid), 32'd1);
        bus.result_ready = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        bus.comp_out     = 1'b0;
        chk("bp_start_stb", 32'(stb), 32'd8);
        chk("bp_start_busy", 32'(bus.busy), 32'd1);
        chk("bp_accept_valid", 32'(bus.result_valid), 32'd0);
        for (int c = 2; c <= 9; c++) begin
            tick();
            bus.comp_out = (c == 8);
            chk($sformatf("n1_stb_c%0d", c), 32'(stb), (c <= 2) ? 32'd8 : (c <= 6) ? 32'd4 : (c <= 8) ? 32'd2 : 32'd0);
        end
        chk("n1_busy_done", 32'(bus.busy), 32'd0);
        chk("n1_result", 32'(bus.result), 32'h0001);
        chk("n1_valid", 32'(bus.result_valid), 32'd1);
        bus.result_ready = 1'b1;
        tick();
        chk("consumed_valid", 32'(bus.result_valid), 32'd0);
        run_conv(5'd0, len);
        chk("clamp0_len", 32'(len), 32'd53);
        chk("clamp0_result", 32'(bus.result), 32'hFFFF);
        chk("clamp0_valid", 32'(bus.result_valid), 32'd1);
        tick();
        run_conv(5'd20, len);
        chk("clamp20_len", 32'(len), 32'd53);
        chk("clamp20_result", 32'(bus.result), 32'hFFFF);
        tick();
        chk("pre_abort_valid", 32'(bus.result_valid), 32'd0);
        bus.cfg_ncomp = 5'd4;
        bus.comp_out  = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 13; c++) tick();
        chk("abort_in_comp3", 32'(stb), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("abort_out", 32'({stb, bus.busy, bus.result_valid, bus.result}), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("abort_after", 32'({stb, bus.busy, bus.result_valid}), 32'd0);
        end
`ifdef ADC_SEQ_CONT_EN
        bus.result_ready = 1'b0;
        bus.cfg_ncomp    = 5'd1;
        bus.comp_out     = 1'b1;
        bus.start        = 1'b1;
        tick();
        chk("cont_c1_stb", 32'(stb), 32'd8);
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (c == 9) begin
                chk("cont_c9_out", 32'({stb, bus.busy, bus.overrun, bus.result_valid}), 32'd1);
                chk("cont_c9_result", 32'(bus.result), 32'h0001);
            end
            if (c == 10) begin
                chk("cont_c10_loop", 32'({stb, bus.busy}), 32'h11);
                bus.comp_out = 1'b0;
            end
            if (c == 18) begin
                chk("cont_c18_overrun", 32'(bus.overrun), 32'd1);
                chk("cont_c18_kept", 32'(bus.result), 32'h0001);
                chk("cont_c18_valid", 32'(bus.result_valid), 32'd1);
                bus.start = 1'b0;
            end
            if (c == 19) begin
                chk("cont_c19_idle", 32'({stb, bus.busy}), 32'd0);
                chk("cont_c19_sticky", 32'(bus.overrun), 32'd1);
                bus.start = 1'b1;
            end
            if (c == 20) begin
                chk("cont_c20_clear", 32'(bus.overrun), 32'd0);
                chk("cont_c20_idle", 32'({stb, bus.busy}), 32'd0);
                bus.start = 1'b0;
            end
        end
`else
        chk("overrun_tied", 32'(bus.overrun), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Conversion sequencer and result collector for the SAR ADC core; it sits on the controlling side of the core's sequencing interface.
- For each conversion it drives the non-overlapping phase strobes seq_init, seq_samp, seq_comp and seq_update.
- It samples the core's serial comparator output once per comparison and assembles the decisions into a right-justified result word.
- It presents the result on a valid/ready handshake to the readout logic.

Parameters:
- NCOMP_MAX, 16, maximum comparisons per conversion and result width.
- INIT_CYC, 2, clock cycles seq_init is high per conversion (>=1).
- SAMP_CYC, 4, clock cycles seq_samp is high per conversion (>=1).
- COMP_CYC, 2, clock cycles seq_comp is high per comparison (>=1).
- UPDATE_CYC, 1, clock cycles seq_update is high between comparisons (>=1).

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request one conversion; single-cycle or level.
- cfg_ncomp  in  5  comparisons per conversion; captured when start is accepted.
- comp_out  in  1  comparator decision from the ADC core (1 means vin_p > vin_n).
- seq_init  out  1  initialization phase strobe.
- seq_samp  out  1  sampling phase strobe.
- seq_comp  out  1  comparison phase strobe.
- seq_update  out  1  DAC update phase strobe.
- busy  out  1  conversion in progress.
- result  out  NCOMP_MAX  assembled conversion result.
- result_valid  out  1  result is held and pending.
- result_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky flag for a dropped result.

Behaviour:
- Interface decided: one clock, clk; reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: all seq_* = 0, busy = 0, result = 0, result_valid = 0, overrun = 0; FSM in IDLE. Reset asserted mid-conversion aborts it; every strobe is low on the cycle after the reset edge, and no partial result is emitted.
- FSM states: IDLE, INIT, SAMP, COMP, UPDATE, DONE.
- Start acceptance: start is accepted in IDLE when start = 1 and (result_valid = 0 or result_ready = 1). Otherwise start is ignored; start requests do not queue.
- cfg_ncomp latch: on acceptance, n = cfg_ncomp. Values 0 or > NCOMP_MAX clamp to NCOMP_MAX. The shift register and bit counter clear.
- Timing from an accepting edge at cycle 0:
  - seq_init is high for cycles 1..INIT_CYC.
  - seq_samp is high for the next SAMP_CYC cycles.
  - Then, for each comparison k = 1..n: seq_comp is high for COMP_CYC cycles. comp_out is captured at the clock edge that ends the last seq_comp cycle, shifted in at the LSB, with earlier bits moving left. For k < n, seq_update then goes high for UPDATE_CYC cycles. No update follows the final comparison.
- Exactly one seq_* strobe is high in any non-IDLE, non-DONE cycle. Strobes never overlap and there is no gap between phases.
- busy is high from cycle 1 through the last seq_comp cycle. Total busy length L = INIT_CYC + SAMP_CYC + n*COMP_CYC + (n-1)*UPDATE_CYC.
- DONE (cycle L+1):
  - result = decisions right-justified; the first decision lands at bit n-1 and upper bits are 0. result_valid = 1.
  - The FSM returns to IDLE, so a new start can be accepted at the earliest at the edge ending cycle L+1.
- Result handshake: result and result_valid hold until an edge with result_valid = 1 and result_ready = 1. After that edge result_valid = 0 unless a new result loads on the same edge; the new result wins.
- cfg_ncomp and start changes during busy are ignored.
- overrun stays 0 unless ADC_SEQ_CONT_EN is defined.

Optional Feature:
- Macro: ADC_SEQ_CONT_EN.
- Defined: the first accepted start enables free-running mode.
  - DONE loops directly to INIT with a freshly latched cfg_ncomp; there are no IDLE cycles between conversions.
  - If result_valid = 1 and result_ready = 0 when a new result completes, the new result is dropped, the old result is kept, and overrun sets.
  - start = 0 sampled in DONE stops the loop and returns to IDLE.
  - overrun clears only on an edge with start = 1 in IDLE, or on reset.
- Undefined: single-shot behaviour as above; overrun is tied to 0.

Test Plan:
- Reset: rst_n = 0 for 3 cycles with start = 1 -> all outputs 0 throughout; no strobe for 1 cycle after release, then conversion begins.
- Basic conversion: defaults, cfg_ncomp = 4, comp_out decisions 1,0,1,1, start pulse at cycle 0 -> seq_init cycles 1-2, seq_samp 3-6, seq_comp 7-8/10-11/13-14/16-17, seq_update 9/12/15, busy 1-17, result = 0x000B with result_valid at 18.
- Clamp: cfg_ncomp = 0 and cfg_ncomp = 20 -> 16 comparisons, busy for 53 cycles; all comp_out = 1 -> result = 0xFFFF.
- Backpressure: result_ready = 0, second start in IDLE -> ignored and result held; raise result_ready together with start -> result accepted and new conversion starts next cycle.
- Abort: rst_n low during the 3rd seq_comp -> strobes and busy 0 the next cycle; result_valid stays 0.
- Continuous mode (ADC_SEQ_CONT_EN): start held, result_ready = 0 -> second completion sets overrun and first result retained; start = 0 -> returns to IDLE after current DONE.
